// File: rtl/bsg_dff_share_arb.sv
// Single holding register shared by several requesters through a round-robin arbiter.
// Accepts a new entry in the same cycle the held entry is consumed downstream.
module bsg_dff_share_arb #(
  parameter int unsigned width_p       = 84,
  parameter int unsigned num_req_p     = 2,
  localparam int unsigned lg_num_req_lp = (num_req_p <= 2) ? 1 : $clog2(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p-1:0]           v_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  output logic [num_req_p-1:0]           yumi_o,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  output logic [lg_num_req_lp-1:0]       id_o,
  input  logic                           yumi_i,
  output logic [15:0]                    count_o
);

  logic                     v_q, v_d;
  logic [width_p-1:0]       data_q, data_d;
  logic [lg_num_req_lp-1:0] id_q, id_d;
  logic [lg_num_req_lp-1:0] last_q, last_d;
  logic [15:0]              count_q, count_d;

  logic                     any_v;
  logic [lg_num_req_lp-1:0] winner;
  logic                     can_accept;
  logic                     accept;
  int unsigned              dist_c;
  int unsigned              best_c;

  // Winner is the valid requester at the smallest rotational distance after last_q.
  always_comb begin
    any_v  = 1'b0;
    winner = '0;
    dist_c = 0;
    best_c = num_req_p;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      dist_c = (r + num_req_p - int'(last_q) - 1) % num_req_p;
      if (v_i[r] && (dist_c < best_c)) begin
        best_c = dist_c;
        winner = lg_num_req_lp'(r);
        any_v  = 1'b1;
      end
    end
  end

  assign can_accept = ~v_q | yumi_i;
  // Gated by reset so no grant escapes while the block is held in reset.
  assign accept     = reset_n_i & any_v & can_accept;

  always_comb begin
    yumi_o = '0;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      yumi_o[r] = accept && (winner == lg_num_req_lp'(r));
    end
  end

  always_comb begin
    v_d     = v_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    count_d = count_q;
    if (accept) begin
      v_d     = 1'b1;
      data_d  = data_i[int'(winner)*width_p +: width_p];
      id_d    = winner;
      last_d  = winner;
      count_d = count_q + 16'd1;
    end else if (yumi_i && v_q) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q     <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= lg_num_req_lp'(num_req_p - 1);
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign v_o     = v_q;
  assign data_o  = data_q;
  assign id_o    = id_q;
  assign count_o = count_q;

  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i) $onehot0(yumi_o));
  a_id_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                               int'(id_q) < num_req_p);
  a_no_grant_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                         (v_q && !yumi_i) |-> (yumi_o == '0));

endmodule

// File: tb/tb_bsg_dff_share_arb.sv
// Randomized and directed bench for bsg_dff_share_arb against a queue-free behavioural model.
module tb_bsg_dff_share_arb;

  localparam int W = 84;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [1:0]    v_i;
  logic [2*W-1:0] data_i;
  logic [1:0]    yumi_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic [0:0]    id_o;
  logic          yumi_i;
  logic [15:0]   count_o;

  logic [2:0]    v3_i;
  logic [23:0]   data3_i;
  logic [2:0]    yumi3_o;
  logic          v3_o;
  logic [7:0]    data3_o;
  logic [1:0]    id3_o;
  logic          yumi3_i;
  logic [15:0]   count3_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the two-requester instance.
  logic          m_v;
  logic [W-1:0]  m_data;
  int            m_id;
  int            m_last;
  logic [15:0]   m_cnt;

  always #5 clk_i = ~clk_i;

  bsg_dff_share_arb #(.width_p(W), .num_req_p(2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .v_o(v_o), .data_o(data_o), .id_o(id_o), .yumi_i(yumi_i), .count_o(count_o)
  );

  bsg_dff_share_arb #(.width_p(8), .num_req_p(3)) dut3 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v3_i), .data_i(data3_i), .yumi_o(yumi3_o),
    .v_o(v3_o), .data_o(data3_o), .id_o(id3_o), .yumi_i(yumi3_i), .count_o(count3_o)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester with v set, searching from last+1 modulo n; -1 if none.
  function automatic int rr_pick(input int last, input int n, input logic [3:0] v);
    for (int k = 1; k <= n; k++) begin
      if (v[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_v = 1'b0; m_data = '0; m_id = 0; m_last = 1; m_cnt = 16'd0;
  endtask

  // Called just after a negedge with inputs already driven; returns at the following negedge.
  task automatic step(input bit do_chk);
    int         w;
    logic [1:0] ey;
    #1;
    w  = rr_pick(m_last, 2, {2'b00, v_i});
    ey = ((m_v && !yumi_i) || (w < 0)) ? 2'b00 : 2'(1 << w);
    if (do_chk) check_val("yumi_o", {126'd0, yumi_o}, {126'd0, ey});
    @(posedge clk_i);
    #1;
    if (ey != 2'b00) begin
      m_v = 1'b1; m_data = data_i[w*W +: W]; m_id = w; m_last = w; m_cnt = m_cnt + 16'd1;
    end else if (yumi_i && m_v) begin
      m_v = 1'b0;
    end
    if (do_chk) begin
      check_val("v_o", {127'd0, v_o}, {127'd0, m_v});
      check_val("data_o", {44'd0, data_o}, {44'd0, m_data});
      check_val("id_o", {127'd0, id_o}, 128'(m_id));
      check_val("count_o", {112'd0, count_o}, {112'd0, m_cnt});
    end
    @(negedge clk_i);
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int last3;
    int w3;
    logic [2:0] e3;
    reset_n_i = 1'b0;
    v_i = '0; data_i = '0; yumi_i = 1'b0;
    v3_i = '0; data3_i = '0; yumi3_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    v_i = 2'b11;
    #1;
    check_val("rst_yumi_o", {126'd0, yumi_o}, 128'd0);
    check_val("rst_v_o", {127'd0, v_o}, 128'd0);
    check_val("rst_data_o", {44'd0, data_o}, 128'd0);
    check_val("rst_count_o", {112'd0, count_o}, 128'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Alternating grants with both requesters valid and downstream always ready.
    data_i = {W'(2), W'(1)};
    yumi_i = 1'b1;
    repeat (3) step(1'b1);
    check_val("alt_id_last", {127'd0, id_o}, 128'd0);

    // Downstream stalled: nothing moves.
    yumi_i = 1'b0;
    data_i = {rand_word(), rand_word()};
    repeat (5) step(1'b1);

    // Only requester 1 valid, then both: requester 0 must follow.
    yumi_i = 1'b1;
    v_i = 2'b10;
    repeat (3) step(1'b1);
    v_i = 2'b11;
    step(1'b1);
    check_val("prio_after_r1", {127'd0, id_o}, 128'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      v_i    = 2'($urandom_range(0, 3));
      yumi_i = ($urandom_range(0, 3) != 0);
      data_i = {rand_word(), rand_word()};
      step(1'b1);
    end

    // Drive the accept counter up to its wrap point.
    v_i = 2'b11; yumi_i = 1'b1;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) step(1'b0);
    check_val("cnt_ffff", {112'd0, count_o}, 128'hFFFF);
    data_i = {rand_word(), rand_word()};
    step(1'b1);
    check_val("cnt_wrap", {112'd0, count_o}, 128'd0);

    // Asynchronous reset in the middle of a cycle with an entry held.
    check_val("pre_rst_v_o", {127'd0, v_o}, 128'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_val("arst_v_o", {127'd0, v_o}, 128'd0);
    check_val("arst_data_o", {44'd0, data_o}, 128'd0);
    check_val("arst_id_o", {127'd0, id_o}, 128'd0);
    check_val("arst_count_o", {112'd0, count_o}, 128'd0);
    check_val("arst_yumi_o", {126'd0, yumi_o}, 128'd0);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    v_i = 2'b11; yumi_i = 1'b1;
    data_i = {rand_word(), rand_word()};
    step(1'b1);
    check_val("post_rst_first", {127'd0, id_o}, 128'd0);
    v_i = 2'b00; yumi_i = 1'b0;

    // Three requesters with the middle one idle.
    last3 = 2;
    v3_i = 3'b101; yumi3_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data3_i = 24'($urandom());
      #1;
      w3 = rr_pick(last3, 3, {1'b0, v3_i});
      e3 = 3'(1 << w3);
      check_val("yumi3_o", {125'd0, yumi3_o}, {125'd0, e3});
      check_val("yumi3_onehot", {127'd0, $onehot0(yumi3_o)}, 128'd1);
      check_val("yumi3_r1", {127'd0, yumi3_o[1]}, 128'd0);
      @(posedge clk_i);
      #1;
      last3 = w3;
      check_val("id3_o", {126'd0, id3_o}, 128'(w3));
      check_val("data3_o", {120'd0, data3_o}, {120'd0, data3_i[w3*8 +: 8]});
      @(negedge clk_i);
    end
    check_val("count3_o", {112'd0, count3_o}, 128'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
